sram_mem_controller: RTL and testbench
======================================

Name: sram_mem_controller

Overview:
- MEM-stage memory controller: converts single-cycle 32-bit load/store requests into multi-cycle accesses on an external 16-bit asynchronous SRAM.
- It is the stall source for the pipeline registers: it holds `ready` low while an access is in flight. The hazard/freeze logic inverts `ready` into the load/freeze controls of the pipeline registers.
- Each 32-bit word takes two half-word SRAM accesses, low half first.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM half-word 0.
- SRAM_AW, 18: SRAM half-word address width.
- WAIT_CYCLES, 2: clock cycles per half-word access. Legal range is 1 or more.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  store request from MEM stage.
- rd_en  input  1  load request from MEM stage.
- address  input  32  byte address of the access.
- wdata  input  32  store data.
- rdata  output  32  load data; valid from the ready-high cycle of a read until the next read completes.
- ready  output  1  high = no access pending, pipeline may advance.
- sram_addr  output  SRAM_AW  SRAM half-word address.
- sram_dq_i  input  16  data from SRAM.
- sram_dq_o  output  16  data to SRAM.
- sram_dq_oe  output  1  high = drive sram_dq_o onto the bus.
- sram_we_n  output  1  active-low SRAM write enable.

Behaviour:
- Reset (rst low, any time, including mid-access):
  - state is IDLE, counter is 0, rdata is 0, latched op/addr/data are 0.
  - sram_we_n is 1, sram_dq_oe is 0, sram_addr is 0, sram_dq_o is 0.
  - Any in-flight access is abandoned.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - ready = ~(rd_en | wr_en), combinational.
  - On a request, latch op, address and wdata, load counter = WAIT_CYCLES-1, go to LO.
  - wr_en has priority when wr_en and rd_en are both high; the access is then a write.
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, computed in 32-bit unsigned arithmetic.
  - LO half-word address = {word[SRAM_AW-2:0], 1'b0}; HI half-word address = LO address | 1.
  - Address bits above the SRAM range are ignored. No range check is performed.
- LO state (WAIT_CYCLES cycles):
  - sram_addr = LO address.
  - Write: sram_we_n = 0, sram_dq_oe = 1, sram_dq_o = wdata[15:0].
  - Read: sram_we_n = 1, sram_dq_oe = 0; capture sram_dq_i into rdata[15:0] at the edge where counter == 0.
  - Counter decrements each cycle. At counter == 0, reload counter = WAIT_CYCLES-1 and go to HI.
- HI state: identical to LO, using the HI address and the [31:16] data halves. At counter == 0, go to DONE.
- DONE (1 cycle):
  - ready = 1, bus idle (sram_we_n = 1, sram_dq_oe = 0).
  - Next state is IDLE unconditionally. The pipeline advances on this edge, so the inputs seen next cycle belong to a new instruction.
- ready is 0 in LO and HI.
- Latency: request first seen in cycle 0; ready is 0 for cycles 0 through 2·WAIT_CYCLES, and ready is 1 in cycle 2·WAIT_CYCLES+1. The freeze therefore lasts 2·WAIT_CYCLES+1 cycles.
- Inputs changing or deasserting during LO/HI are ignored; the access always completes using the latched values.
- rdata:
  - Only reads update rdata; writes leave it unchanged.
  - The upper half keeps its old value until the HI capture edge.
- sram_we_n and sram_dq_oe are registered or decoded from state only, so they are glitch-free with respect to the request inputs.

Test Plan:
1. Reset and idle:
   - Stimulus: rst low mid-simulation with no request.
   - Required: rdata = 0, ready = 1, sram_we_n = 1, sram_dq_oe = 0, sram_addr = 0.
2. Store, WAIT_CYCLES = 2:
   - Stimulus: wr_en = 1, address = 1024, wdata = 0xDEADBEEF.
   - Required: ready low for 5 cycles.
   - Required: sram_addr = 0 with sram_dq_o = 0xBEEF, sram_we_n = 0 for 2 cycles.
   - Required: then sram_addr = 1 with sram_dq_o = 0xDEAD for 2 cycles.
   - Required: then ready = 1 for one cycle.
3. Load, WAIT_CYCLES = 2:
   - Stimulus: SRAM model returns 0x1234 at half-word 2 and 0xABCD at half-word 3; rd_en = 1, address = 1028.
   - Required: sram_addr = 2 then 3, sram_dq_oe = 0 throughout.
   - Required: rdata = 0xABCD1234 when ready rises, and held afterwards.
4. Simultaneous rd_en and wr_en:
   - Stimulus: both high, address = 1032, wdata = 0x55AA00FF.
   - Required: a write is performed to half-words 4 and 5; rdata is unchanged.
5. Reset mid-access:
   - Stimulus: rst low during the HI phase of a write.
   - Required: next state is IDLE, sram_we_n = 1 immediately, rdata = 0; a new read after release completes normally.
6. Back-to-back accesses:
   - Stimulus: a load immediately following a store.
   - Required: second access starts the cycle after DONE, with no lost or duplicated half-word writes.
   - Repeat with WAIT_CYCLES = 1: ready low exactly 3 cycles per access.

Source files
------------

// File: rtl/sram_mem_controller.sv
// MEM-stage SRAM controller: splits each 32-bit load/store into two
// half-word accesses on a 16-bit asynchronous SRAM, low half first.
// ready stays low while an access is in flight and stalls the pipeline.
module sram_mem_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [15:0]        sram_dq_i,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);
  localparam logic [SRAM_AW-1:0] HW_ONE = {{(SRAM_AW-1){1'b0}}, 1'b1};

  state_t             state_r, state_nxt_s;
  logic [CW-1:0]      cnt_r, cnt_nxt_s;
  logic               op_wr_r, op_wr_nxt_s;
  logic [SRAM_AW-1:0] addr_r, addr_nxt_s;
  logic [31:0]        wdata_r, wdata_nxt_s;
  logic [31:0]        rdata_r, rdata_nxt_s;
  logic [SRAM_AW-1:0] sram_addr_r, sram_addr_nxt_s;
  logic [15:0]        sram_dq_o_r, sram_dq_o_nxt_s;
  logic               sram_dq_oe_r, sram_dq_oe_nxt_s;
  logic               sram_we_n_r, sram_we_n_nxt_s;
  logic               ready_s;

  // Byte offset from the SRAM window; bits outside the half-word range are dropped.
  logic [31:0]        ofs_s;
  logic [SRAM_AW-1:0] lo_in_s;
  logic               unused_ofs_s;
  assign ofs_s        = address - BASE_ADDR;
  assign lo_in_s      = {ofs_s[SRAM_AW:2], 1'b0};
  assign unused_ofs_s = ^{ofs_s[31:SRAM_AW+1], ofs_s[1:0]};

  // Next-state, latch, capture and ready decode for the access sequencer.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    op_wr_nxt_s = op_wr_r;
    addr_nxt_s  = addr_r;
    wdata_nxt_s = wdata_r;
    rdata_nxt_s = rdata_r;
    ready_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ready_s = ~(rd_en | wr_en);
        if (wr_en | rd_en) begin
          state_nxt_s = ST_LO;
          cnt_nxt_s   = CNT_LOAD;
          op_wr_nxt_s = wr_en;
          addr_nxt_s  = lo_in_s;
          wdata_nxt_s = wdata;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LO: begin
        if (cnt_r == '0) begin
          if (!op_wr_r) begin
            rdata_nxt_s[15:0] = sram_dq_i;
          end else begin
            rdata_nxt_s[15:0] = rdata_r[15:0];
          end
          cnt_nxt_s   = CNT_LOAD;
          state_nxt_s = ST_HI;
        end else begin
          cnt_nxt_s = cnt_r - CW'(1'b1);
        end
      end
      ST_HI: begin
        if (cnt_r == '0) begin
          if (!op_wr_r) begin
            rdata_nxt_s[31:16] = sram_dq_i;
          end else begin
            rdata_nxt_s[31:16] = rdata_r[31:16];
          end
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s = cnt_r - CW'(1'b1);
        end
      end
      ST_DONE: begin
        ready_s     = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Bus drive for the coming cycle, decoded from the next state so outputs leave flops.
  always_comb begin
    sram_addr_nxt_s  = '0;
    sram_dq_o_nxt_s  = 16'h0000;
    sram_dq_oe_nxt_s = 1'b0;
    sram_we_n_nxt_s  = 1'b1;
    case (state_nxt_s)
      ST_LO: begin
        sram_addr_nxt_s  = addr_nxt_s;
        sram_dq_oe_nxt_s = op_wr_nxt_s;
        sram_we_n_nxt_s  = ~op_wr_nxt_s;
        sram_dq_o_nxt_s  = op_wr_nxt_s ? wdata_nxt_s[15:0] : 16'h0000;
      end
      ST_HI: begin
        sram_addr_nxt_s  = addr_nxt_s | HW_ONE;
        sram_dq_oe_nxt_s = op_wr_nxt_s;
        sram_we_n_nxt_s  = ~op_wr_nxt_s;
        sram_dq_o_nxt_s  = op_wr_nxt_s ? wdata_nxt_s[31:16] : 16'h0000;
      end
      default: begin
        sram_addr_nxt_s  = '0;
        sram_dq_o_nxt_s  = 16'h0000;
        sram_dq_oe_nxt_s = 1'b0;
        sram_we_n_nxt_s  = 1'b1;
      end
    endcase
  end

  // State, latched request, read data and registered SRAM bus; reset abandons any access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      op_wr_r      <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= 32'h0000_0000;
      rdata_r      <= 32'h0000_0000;
      sram_addr_r  <= '0;
      sram_dq_o_r  <= 16'h0000;
      sram_dq_oe_r <= 1'b0;
      sram_we_n_r  <= 1'b1;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      op_wr_r      <= op_wr_nxt_s;
      addr_r       <= addr_nxt_s;
      wdata_r      <= wdata_nxt_s;
      rdata_r      <= rdata_nxt_s;
      sram_addr_r  <= sram_addr_nxt_s;
      sram_dq_o_r  <= sram_dq_o_nxt_s;
      sram_dq_oe_r <= sram_dq_oe_nxt_s;
      sram_we_n_r  <= sram_we_n_nxt_s;
    end
  end

  assign rdata      = rdata_r;
  assign ready      = ready_s;
  assign sram_addr  = sram_addr_r;
  assign sram_dq_o  = sram_dq_o_r;
  assign sram_dq_oe = sram_dq_oe_r;
  assign sram_we_n  = sram_we_n_r;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: two instances (WAIT_CYCLES 2 and 1), each
// with a behavioural 16-bit SRAM, driven from a table of directed accesses.
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en [2];
  logic        rd_en [2];
  logic [31:0] address [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic [17:0] sram_addr [2];
  logic [15:0] dq_i [2];
  logic [15:0] dq_o [2];
  logic        oe [2];
  logic        we_n [2];

  logic [15:0] mem [2][64];
  int          wcyc [2] = '{0, 0};
  logic        pre_en;
  int          pre_k;
  logic [5:0]  pre_a;
  logic [15:0] pre_d;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_rd_r [2];

  typedef struct {
    int          k;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] lo;
    logic [31:0] exp_rd;
    int          gap;
  } vec_t;
  vec_t vecs [12];

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  sram_mem_controller #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .wr_en(wr_en[0]), .rd_en(rd_en[0]), .address(address[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .sram_addr(sram_addr[0]),
    .sram_dq_i(dq_i[0]), .sram_dq_o(dq_o[0]), .sram_dq_oe(oe[0]), .sram_we_n(we_n[0])
  );

  sram_mem_controller #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[1]), .rd_en(rd_en[1]), .address(address[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .sram_addr(sram_addr[1]),
    .sram_dq_i(dq_i[1]), .sram_dq_o(dq_o[1]), .sram_dq_oe(oe[1]), .sram_we_n(we_n[1])
  );

  assign dq_i[0] = mem[0][sram_addr[0][5:0]];
  assign dq_i[1] = mem[1][sram_addr[1][5:0]];

  // SRAM models: preload port plus write on every edge with we_n low.
  always @(posedge clk) begin
    if (pre_en) mem[pre_k][pre_a] <= pre_d;
    for (int k = 0; k < 2; k++) begin
      if (!we_n[k]) begin
        mem[k][sram_addr[k][5:0]] <= dq_o[k];
        wcyc[k] <= wcyc[k] + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_bus(input int k, input string tag);
    chk({tag, "_ready"}, {31'd0, ready[k]}, 32'd1);
    chk({tag, "_we_n"},  {31'd0, we_n[k]},  32'd1);
    chk({tag, "_oe"},    {31'd0, oe[k]},    32'd0);
  endtask

  // Entered just after a rising edge with the DUT idle; returns likewise.
  task automatic run(input int k, input logic wr, input logic rd, input logic [31:0] a,
                     input logic [31:0] d, input logic [17:0] lo, input logic [31:0] exp_rd);
    int w;
    int wc0;
    logic [17:0] hi;
    w   = (k == 0) ? 2 : 1;
    hi  = lo | 18'd1;
    wc0 = wcyc[k];
    wr_en[k] = wr; rd_en[k] = rd; address[k] = a; wdata[k] = d;
    for (int c = 0; c <= 2 * w + 1; c++) begin
      @(negedge clk);
      if (c == 2 * w + 1) begin
        chk_idle_bus(k, "done");
        chk("rdata_done", rdata[k], exp_rd);
      end else begin
        chk("ready_busy", {31'd0, ready[k]}, 32'd0);
        if (c == 0) begin
          chk("we_n_req", {31'd0, we_n[k]}, 32'd1);
          chk("oe_req",   {31'd0, oe[k]},   32'd0);
        end else begin
          chk("sram_addr", {14'd0, sram_addr[k]}, {14'd0, (c <= w) ? lo : hi});
          chk("we_n", {31'd0, we_n[k]}, {31'd0, ~wr});
          chk("oe",   {31'd0, oe[k]},   {31'd0, wr});
          if (wr) chk("dq_o", {16'd0, dq_o[k]}, {16'd0, (c <= w) ? d[15:0] : d[31:16]});
          if (!wr && c == w + 1) begin
            chk("rdata_lo_cap",  {16'd0, rdata[k][15:0]},  {16'd0, exp_rd[15:0]});
            chk("rdata_hi_held", {16'd0, rdata[k][31:16]}, {16'd0, exp_rd_r[k][31:16]});
          end
        end
      end
      @(posedge clk); #1;
    end
    wr_en[k] = 1'b0; rd_en[k] = 1'b0;
    exp_rd_r[k] = exp_rd;
    chk("write_cycles", wcyc[k] - wc0, wr ? 2 * w : 0);
    if (wr) begin
      chk("mem_lo", {16'd0, mem[k][lo[5:0]]}, {16'd0, d[15:0]});
      chk("mem_hi", {16'd0, mem[k][hi[5:0]]}, {16'd0, d[31:16]});
    end
  endtask

  initial begin
    vecs[0]  = '{0, 1'b1, 1'b0, 32'd1024,      32'hDEADBEEF, 18'h00000, 32'h00000000, 0};
    vecs[1]  = '{0, 1'b0, 1'b1, 32'd1028,      32'h00000000, 18'h00002, 32'hABCD1234, 0};
    vecs[2]  = '{0, 1'b1, 1'b1, 32'd1032,      32'h55AA00FF, 18'h00004, 32'hABCD1234, 0};
    vecs[3]  = '{0, 1'b0, 1'b1, 32'd1032,      32'h00000000, 18'h00004, 32'h55AA00FF, 2};
    vecs[4]  = '{0, 1'b1, 1'b0, 32'd1020,      32'h0BADF00D, 18'h3FFFE, 32'h55AA00FF, 0};
    vecs[5]  = '{0, 1'b0, 1'b1, 32'd1020,      32'h00000000, 18'h3FFFE, 32'h0BADF00D, 1};
    vecs[6]  = '{0, 1'b0, 1'b1, 32'd1024,      32'h00000000, 18'h00000, 32'hDEADBEEF, 0};
    vecs[7]  = '{0, 1'b0, 1'b1, 32'h00100400,  32'h00000000, 18'h00000, 32'hDEADBEEF, 0};
    vecs[8]  = '{1, 1'b1, 1'b0, 32'd1024,      32'h12345678, 18'h00000, 32'h00000000, 1};
    vecs[9]  = '{1, 1'b0, 1'b1, 32'd1024,      32'h00000000, 18'h00000, 32'h12345678, 0};
    vecs[10] = '{1, 1'b1, 1'b0, 32'd1036,      32'hA5A5C3C3, 18'h00006, 32'h12345678, 0};
    vecs[11] = '{1, 1'b0, 1'b1, 32'd1036,      32'h00000000, 18'h00006, 32'hA5A5C3C3, 0};

    rst = 1'b0; pre_en = 1'b0; pre_k = 0; pre_a = 6'd0; pre_d = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      wr_en[k] = 1'b0; rd_en[k] = 1'b0; address[k] = 32'd0; wdata[k] = 32'd0;
      exp_rd_r[k] = 32'd0;
    end

    // Reset and idle.
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk_idle_bus(k, "rst");
      chk("rst_rdata", rdata[k], 32'd0);
      chk("rst_addr",  {14'd0, sram_addr[k]}, 32'd0);
      chk("rst_dq_o",  {16'd0, dq_o[k]}, 32'd0);
    end
    rst = 1'b1;

    // SRAM preload: half-word 2 = 0x1234, half-word 3 = 0xABCD.
    @(posedge clk); #1;
    pre_en = 1'b1; pre_k = 0; pre_a = 6'd2; pre_d = 16'h1234;
    @(posedge clk); #1;
    pre_a = 6'd3; pre_d = 16'hABCD;
    @(posedge clk); #1;
    pre_en = 1'b0;

    // Table of accesses; a zero gap means back-to-back with the previous one.
    for (int i = 0; i < 12; i++) begin
      for (int g = 0; g < vecs[i].gap; g++) begin
        @(negedge clk);
        chk_idle_bus(vecs[i].k, "gap");
        @(posedge clk); #1;
      end
      run(vecs[i].k, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].lo, vecs[i].exp_rd);
    end

    // Reset during the HI phase of a write to word 0.
    wr_en[0] = 1'b1; rd_en[0] = 1'b0; address[0] = 32'd1024; wdata[0] = 32'hCAFEF00D;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("midrst_pre_addr", {14'd0, sram_addr[0]}, 32'd1);
    chk("midrst_pre_we_n", {31'd0, we_n[0]}, 32'd0);
    #1;
    wr_en[0] = 1'b0;
    rst = 1'b0;
    #1;
    chk_idle_bus(0, "midrst");
    chk("midrst_addr",  {14'd0, sram_addr[0]}, 32'd0);
    chk("midrst_rdata", rdata[0], 32'd0);
    chk("midrst_rdata1", rdata[1], 32'd0);
    exp_rd_r[0] = 32'd0;
    exp_rd_r[1] = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // LO half of the abandoned write landed, HI half did not.
    run(0, 1'b0, 1'b1, 32'd1024, 32'd0, 18'h00000, 32'hDEADF00D);
    run(1, 1'b0, 1'b1, 32'd1036, 32'd0, 18'h00006, 32'hA5A5C3C3);

    @(negedge clk);
    chk_idle_bus(0, "end0");
    chk_idle_bus(1, "end1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
